// File: rtl/motion_pkg.sv
// Shared types and helpers for the motion-mask consumer of the sigma-delta background model.
package motion_pkg;

  // Default pixel width used by the top-level parameter.
  localparam int DEFAULT_PIX_W = 8;

  // Pipeline stage fields are sized for the widest supported configuration.
  // Narrower pixels are zero-extended into them, so PIX_W must not exceed MAX_PIX_W
  // and variance*N_GAIN must fit in MAX_THR_W bits.
  localparam int MAX_PIX_W = 16;
  localparam int MAX_THR_W = 32;

  // Input-side frame tracking.
  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  // Contents of the first pipeline register.
  // abort marks the sof beat that cut short an unfinished frame.
  // detect is low for beats that belong to background-initialisation frames.
  typedef struct packed {
    logic [MAX_PIX_W-1:0] diff;
    logic [MAX_THR_W-1:0] thr;
    logic                 sof;
    logic                 eof;
    logic                 abort;
    logic                 detect;
  } stage_t;

  // Absolute difference of two unsigned samples.
  function automatic logic [MAX_PIX_W-1:0] abs_diff(input logic [MAX_PIX_W-1:0] a,
                                                    input logic [MAX_PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/motion_threshold.sv
// Motion decision for one registered pixel: strictly above the scaled variance counts as motion.
module motion_threshold
  import motion_pkg::*;
(
  input  logic [MAX_PIX_W-1:0] diff,
  input  logic [MAX_THR_W-1:0] thr,
  input  logic                 detect,
  output logic                 motion
);

  // Compare at the threshold width so a large threshold can never wrap below the difference.
  always_comb begin
    motion = detect & (MAX_THR_W'(diff) > thr);
  end

endmodule

// File: rtl/motion_mask_gen.sv
// Streams pixels against their stored background/variance, emits a 1-bit motion mask
// and a per-frame motion-pixel count, and requests direct background loads during the
// first INIT_FRAMES complete frames.
module motion_mask_gen
  import motion_pkg::*;
#(
  parameter int PIX_W       = DEFAULT_PIX_W,
  parameter int N_GAIN      = 2,
  parameter int INIT_FRAMES = 1,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [PIX_W-1:0] curr_pixel,
  input  logic [PIX_W-1:0] background,
  input  logic [PIX_W-1:0] variance,
  output logic             wr_background,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             motion,
  output logic             out_sof,
  output logic             out_eof,
  output logic             frame_done,
  output logic [CNT_W-1:0] motion_count
);

  localparam int             FC_W     = (INIT_FRAMES < 1) ? 1 : $clog2(INIT_FRAMES + 1);
  localparam logic [FC_W-1:0] INIT_LIM = FC_W'(INIT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic             adv;
  logic             in_fire;
  logic             out_fire;
  logic             fwd;
  logic             abort_beat;
  logic             frame_end;
  logic [FC_W-1:0]  frame_cnt;
  logic             s1_valid;
  stage_t           s1;
  stage_t           s1_nxt;
  logic             thr_motion;
  logic             out_abort;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_base;
  logic [CNT_W-1:0] acc_sum;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign adv      = !out_valid | out_ready;
  assign in_ready = enable & adv;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Background is loaded directly until enough complete frames have been seen.
  assign wr_background = (frame_cnt < INIT_LIM);

  // Frame-tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (!enable) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A sof always (re)starts a frame; eof closes it; other beats leave the state alone.
  always_comb begin
    state_nxt = state;
    if (in_fire) begin
      if (in_sof) begin
        state_nxt = in_eof ? IDLE : IN_FRAME;
      end else if ((state == IN_FRAME) && in_eof) begin
        state_nxt = IDLE;
      end
    end
  end

  // Classify each accepted beat: forwarded, aborting an open frame, or closing a complete frame.
  always_comb begin
    fwd        = 1'b0;
    abort_beat = 1'b0;
    frame_end  = 1'b0;
    if (in_fire) begin
      fwd        = in_sof | (state == IN_FRAME);
      abort_beat = in_sof & (state == IN_FRAME);
      frame_end  = in_eof & (in_sof | (state == IN_FRAME));
    end
  end

  // Count completed frames up to the initialisation limit; aborted frames never reach here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (!enable) begin
      frame_cnt <= '0;
    end else if (frame_end && wr_background) begin
      frame_cnt <= frame_cnt + FC_W'(1);
    end
  end

  // Difference and scaled threshold for the beat currently on the input.
  always_comb begin
    s1_nxt.diff   = abs_diff(MAX_PIX_W'(curr_pixel), MAX_PIX_W'(background));
    s1_nxt.thr    = MAX_THR_W'(variance) * MAX_THR_W'(N_GAIN);
    s1_nxt.sof    = in_sof;
    s1_nxt.eof    = in_eof;
    s1_nxt.abort  = abort_beat;
    s1_nxt.detect = !wr_background;
  end

  // First pipeline stage; beats dropped while idle simply leave a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (!enable) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (adv) begin
      s1_valid <= fwd;
      s1       <= s1_nxt;
    end
  end

  motion_threshold u_threshold (
    .diff   (s1.diff),
    .thr    (s1.thr),
    .detect (s1.detect),
    .motion (thr_motion)
  );

  // Output stage; flags are forced low on bubbles so idle outputs read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      motion    <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_abort <= 1'b0;
    end else if (!enable) begin
      out_valid <= 1'b0;
      motion    <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      out_abort <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      motion    <= s1_valid & thr_motion;
      out_sof   <= s1_valid & s1.sof;
      out_eof   <= s1_valid & s1.eof;
      out_abort <= s1_valid & s1.abort;
    end
  end

  // Running total including the beat on the output; a new or aborting frame restarts from zero.
  always_comb begin
    acc_base = (out_sof | out_abort) ? '0 : acc;
    acc_sum  = acc_base;
    if (motion && (acc_base != CNT_MAX)) begin
      acc_sum = acc_base + CNT_W'(1);
    end
  end

  // Accumulate leaving beats and publish the total one cycle after a frame's eof leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      motion_count <= '0;
      frame_done   <= 1'b0;
    end else if (!enable) begin
      acc          <= '0;
      motion_count <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (out_fire) begin
        if (out_eof) begin
          acc          <= '0;
          motion_count <= acc_sum;
          frame_done   <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_motion_mask_gen.sv
// Self-checking bench for motion_mask_gen: table-driven detect vectors, hand-written
// corner sequences and a randomized run against a beat-level reference model.
module tb_motion_mask_gen;
  import motion_pkg::*;

  localparam int PIX_W       = 8;
  localparam int N_GAIN      = 2;
  localparam int INIT_FRAMES = 1;
  localparam int CNT_W       = 20;
  localparam int CNT_W_S     = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             in_valid;
  logic             in_sof;
  logic             in_eof;
  logic [PIX_W-1:0] curr_pixel;
  logic [PIX_W-1:0] background;
  logic [PIX_W-1:0] variance;
  logic             out_ready;

  logic               in_ready, wr_background, out_valid, motion, out_sof, out_eof, frame_done;
  logic [CNT_W-1:0]   motion_count;
  logic               in_ready_s, wr_background_s, out_valid_s, motion_s, out_sof_s, out_eof_s;
  logic               frame_done_s;
  logic [CNT_W_S-1:0] motion_count_s;

  always #5 clk = ~clk;

  motion_mask_gen #(
    .PIX_W(PIX_W), .N_GAIN(N_GAIN), .INIT_FRAMES(INIT_FRAMES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_eof(in_eof), .curr_pixel(curr_pixel), .background(background),
    .variance(variance), .wr_background(wr_background), .out_valid(out_valid),
    .out_ready(out_ready), .motion(motion), .out_sof(out_sof), .out_eof(out_eof),
    .frame_done(frame_done), .motion_count(motion_count)
  );

  motion_mask_gen #(
    .PIX_W(PIX_W), .N_GAIN(N_GAIN), .INIT_FRAMES(INIT_FRAMES), .CNT_W(CNT_W_S)
  ) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_sof(in_sof), .in_eof(in_eof), .curr_pixel(curr_pixel), .background(background),
    .variance(variance), .wr_background(wr_background_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .motion(motion_s), .out_sof(out_sof_s), .out_eof(out_eof_s),
    .frame_done(frame_done_s), .motion_count(motion_count_s)
  );

  typedef struct {
    logic motion;
    logic sof;
    logic eof;
  } beat_t;

  typedef struct {
    logic [7:0] pix;
    logic [7:0] bg;
    logic [7:0] vr;
    logic       sof;
    logic       eof;
    logic       exp_motion;
    int         exp_count;
  } vec_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    m_frame_cnt;
  bit    m_in_frame;
  int    m_acc;
  int    m_last;
  bit    m_done_exp;
  bit    stall_prev;
  int    done_seen;

  // Saturating view of an unbounded count for a given counter width.
  function automatic int sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_frame_cnt = 0;
    m_in_frame  = 1'b0;
    m_acc       = 0;
    m_last      = 0;
    m_done_exp  = 1'b0;
    stall_prev  = 1'b0;
  endtask

  task automatic apply_stimulus(input logic v, input logic s, input logic e,
                                input logic [7:0] p, input logic [7:0] b, input logic [7:0] vr);
    in_valid   = v;
    in_sof     = s;
    in_eof     = e;
    curr_pixel = p;
    background = b;
    variance   = vr;
  endtask

  // One clock: sample and check at the falling edge, update the model, return after the rising edge.
  task automatic tick(output bit accepted);
    beat_t b;
    int    d;
    int    t;
    bit    det;
    accepted = 1'b0;
    @(negedge clk);
    check_output("frame_done", frame_done, m_done_exp);
    check_output("frame_done_sat", frame_done_s, m_done_exp);
    check_output("motion_count", motion_count, sat(m_last, CNT_W));
    check_output("motion_count_sat", motion_count_s, sat(m_last, CNT_W_S));
    if (frame_done === 1'b1) done_seen++;
    m_done_exp = 1'b0;
    if (stall_prev) check_output("stall_valid_held", out_valid, 1);
    stall_prev = 1'b0;
    if (enable && out_valid === 1'b1 && !out_ready) begin
      if (exp_q.size() > 0) begin
        check_output("stall_motion", motion, exp_q[0].motion);
        check_output("stall_sof", out_sof, exp_q[0].sof);
        check_output("stall_eof", out_eof, exp_q[0].eof);
      end else begin
        fail_now("stall_spurious_beat", 1, 0);
      end
      stall_prev = 1'b1;
    end
    if (!enable) begin
      check_output("in_ready_disabled", in_ready, 0);
      model_clear();
    end else begin
      if (out_ready) check_output("in_ready_open", in_ready, 1);
      if (in_valid) check_output("wr_background", wr_background, (m_frame_cnt < INIT_FRAMES));
      if (out_valid === 1'b1 && out_ready) begin
        obs_q.push_back('{motion, out_sof, out_eof});
        if (exp_q.size() == 0) begin
          fail_now("spurious_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check_output("motion", motion, b.motion);
          check_output("out_sof", out_sof, b.sof);
          check_output("out_eof", out_eof, b.eof);
          if (b.sof) m_acc = 0;
          if (b.motion) m_acc++;
          if (b.eof) begin
            m_last     = m_acc;
            m_acc      = 0;
            m_done_exp = 1'b1;
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        accepted = 1'b1;
        if (in_sof || m_in_frame) begin
          det = !(m_frame_cnt < INIT_FRAMES);
          d   = (curr_pixel > background) ? int'(curr_pixel) - int'(background)
                                          : int'(background) - int'(curr_pixel);
          t   = int'(variance) * N_GAIN;
          exp_q.push_back('{det && (d > t), in_sof, in_eof});
          if (in_eof) begin
            m_in_frame = 1'b0;
            if (m_frame_cnt < INIT_FRAMES) m_frame_cnt++;
          end else begin
            m_in_frame = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic s, input logic e,
                           input logic [7:0] p, input logic [7:0] b, input logic [7:0] vr);
    bit a;
    int n;
    apply_stimulus(1'b1, s, e, p, b, vr);
    a = 1'b0;
    n = 0;
    while (!a && n < 50) begin
      tick(a);
      n++;
    end
    if (!a) fail_now("send_timeout_cycles", n, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(a);
    tick(a);
    check_output("drain_left_in_queue", exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    bit a;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(a);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    bit   a;

    rst = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    model_clear();
    done_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_motion", motion, 0);
    check_output("rst_out_sof", out_sof, 0);
    check_output("rst_out_eof", out_eof, 0);
    check_output("rst_frame_done", frame_done, 0);
    check_output("rst_motion_count", motion_count, 0);
    check_output("rst_wr_background", wr_background, 1);
    check_output("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Initialisation frame: strong differences but no motion reported
    obs_q.delete();
    done_seen = 0;
    send_beat(1'b1, 1'b0, 8'd200, 8'd0, 8'd0);
    send_beat(1'b0, 1'b0, 8'd0, 8'd200, 8'd0);
    send_beat(1'b0, 1'b0, 8'd255, 8'd0, 8'd1);
    send_beat(1'b0, 1'b1, 8'd90, 8'd10, 8'd2);
    drain();
    check_output("init_beats_out", obs_q.size(), 4);
    foreach (obs_q[i]) check_output("init_motion", obs_q[i].motion, 0);
    check_output("init_frame_done_pulses", done_seen, 1);
    check_output("init_count", motion_count, 0);
    check_output("init_wr_background_after", wr_background, 0);

    // Detect frames from a table
    vecs[0] = '{8'd100, 8'd90,  8'd4,   1'b1, 1'b0, 1'b1, 0};
    vecs[1] = '{8'd95,  8'd90,  8'd4,   1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{8'd255, 8'd0,   8'd200, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{8'd0,   8'd255, 8'd127, 1'b0, 1'b1, 1'b1, 2};
    vecs[4] = '{8'd7,   8'd7,   8'd0,   1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{8'd10,  8'd0,   8'd5,   1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{8'd11,  8'd0,   8'd5,   1'b0, 1'b0, 1'b1, 0};
    vecs[7] = '{8'd0,   8'd11,  8'd5,   1'b0, 1'b1, 1'b1, 2};
    obs_q.delete();
    for (int i = 0; i < 8; i++) begin
      send_beat(vecs[i].sof, vecs[i].eof, vecs[i].pix, vecs[i].bg, vecs[i].vr);
      if (vecs[i].eof) begin
        drain();
        check_output("table_count", motion_count, vecs[i].exp_count);
      end
    end
    check_output("table_beats_out", obs_q.size(), 8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++)
      check_output("table_motion", obs_q[i].motion, vecs[i].exp_motion);

    // Backpressure with a full pipeline
    obs_q.delete();
    out_ready = 1'b0;
    send_beat(1'b1, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b0, 1'b0, 8'd95, 8'd90, 8'd4);
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'd11, 8'd0, 8'd5);
    for (int i = 0; i < 3; i++) begin
      tick(a);
      check_output("bp_accepted", a, 0);
      check_output("bp_in_ready", in_ready, 0);
      check_output("bp_out_valid", out_valid, 1);
      check_output("bp_out_sof", out_sof, 1);
      check_output("bp_motion", motion, 1);
    end
    out_ready = 1'b1;
    send_beat(1'b0, 1'b0, 8'd11, 8'd0, 8'd5);
    send_beat(1'b0, 1'b1, 8'd0, 8'd11, 8'd5);
    drain();
    check_output("bp_beats_out", obs_q.size(), 4);
    check_output("bp_count", motion_count, 3);

    // Frame aborted by a second sof
    done_seen = 0;
    send_beat(1'b1, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b0, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b1, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b0, 1'b0, 8'd95, 8'd90, 8'd4);
    send_beat(1'b0, 1'b0, 8'd0, 8'd255, 8'd127);
    send_beat(1'b0, 1'b1, 8'd100, 8'd90, 8'd4);
    drain();
    check_output("abort_frame_done_pulses", done_seen, 1);
    check_output("abort_count", motion_count, 3);
    check_output("abort_wr_background", wr_background, 0);

    // enable low for one cycle mid-frame
    send_beat(1'b1, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b0, 1'b0, 8'd100, 8'd90, 8'd4);
    enable = 1'b0;
    tick(a);
    enable = 1'b1;
    check_output("en_out_valid", out_valid, 0);
    check_output("en_frame_done", frame_done, 0);
    check_output("en_motion_count", motion_count, 0);
    check_output("en_wr_background", wr_background, 1);
    obs_q.delete();
    send_beat(1'b0, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b0, 1'b1, 8'd100, 8'd90, 8'd4);
    idle(3);
    check_output("en_dropped_beats", obs_q.size(), 0);
    check_output("en_dropped_valid", out_valid, 0);
    done_seen = 0;
    send_beat(1'b1, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b0, 1'b1, 8'd200, 8'd0, 8'd4);
    drain();
    check_output("en_reinit_done", done_seen, 1);
    check_output("en_reinit_count", motion_count, 0);
    check_output("en_reinit_wr_background", wr_background, 0);

    // Saturating count with a 3-bit counter
    for (int i = 0; i < 10; i++) send_beat(i == 0, i == 9, 8'd100, 8'd90, 8'd4);
    drain();
    check_output("sat_count_wide", motion_count, 10);
    check_output("sat_count_narrow", motion_count_s, 7);

    // Asynchronous reset mid-frame
    send_beat(1'b1, 1'b0, 8'd100, 8'd90, 8'd4);
    send_beat(1'b0, 1'b0, 8'd100, 8'd90, 8'd4);
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_out_valid", out_valid, 0);
    check_output("arst_wr_background", wr_background, 1);
    check_output("arst_motion_count", motion_count, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    obs_q.delete();
    send_beat(1'b0, 1'b1, 8'd100, 8'd90, 8'd4);
    idle(3);
    check_output("arst_dropped_beats", obs_q.size(), 0);

    // Randomized traffic against the model
    apply_stimulus(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 199) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick(a);
      if (a || !in_valid) begin
        background = 8'($urandom_range(0, 255));
        curr_pixel = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 255))
                                                 : 8'(int'(background) + $urandom_range(0, 12));
        variance   = 8'($urandom_range(0, 10));
        in_valid   = ($urandom_range(0, 3) != 0);
        in_sof     = ($urandom_range(0, 7) == 0);
        in_eof     = ($urandom_range(0, 5) == 0);
      end
    end
    enable = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
